uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one uart_tx; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 50000: clk cycles allowed from issue to tx_done rise; must be at least 1.
REQ-003 Port clk, input, 1: single clock; all logic on posedge.
REQ-004 Port rst, input, 1: synchronous, active-low reset.
REQ-005 Port req, input, NREQ: level request per requester; requester holds it high until its ack.
REQ-006 Port req_dat, input, 8*NREQ: byte i is req_dat[8i+7:8i]; requester holds it stable while req[i] is high.
REQ-007 Port ack, output, NREQ: one-cycle pulse on the owning bit when its byte has completed.
REQ-008 Port grant, output, NREQ: one-hot owner of the uart_tx; all zeros when no owner.
REQ-009 Port busy, output, 1: high whenever the state is not IDLE.
REQ-010 Port new_dat, output, 1: drives uart_tx new_dat.
REQ-011 Port tx_dat, output, 8: drives uart_tx tx_dat.
REQ-012 Port tx_done, input, 1: from uart_tx; high for one baud period after the stop bit.
REQ-013 Port timeout, output, 1: one-cycle abort pulse.

Function
REQ-014 The FSM shall have three states: IDLE, ISSUE and RELEASE; all outputs shall be registered.
REQ-015 The block shall register tx_done into tx_done_q each cycle; rise is defined as tx_done & ~tx_done_q.
REQ-016 IDLE: when req is non-zero and tx_done is low, the block shall pick the winner by round-robin, starting at (last+1) mod NREQ.
REQ-017 IDLE to ISSUE: in the next cycle, grant shall be one-hot for the winner, tx_dat shall be the winner's byte, new_dat shall be 1, and last shall be set to the winner. Latency from req to new_dat is 1 clk.
REQ-018 IDLE with tx_done high: the block shall stay in IDLE and grant nothing.
REQ-019 ISSUE: new_dat and tx_dat shall be held stable until rise. On rise: new_dat goes to 0, ack pulses for the grant index in that same registered update, and the state moves to RELEASE.
REQ-020 RELEASE: grant stays held until tx_done is sampled low; then grant clears and the state moves to IDLE.
REQ-021 A req still high after its ack shall be treated as a new byte. It waits for round-robin like any other request.
REQ-022 Changes on req or req_dat while a requester is not granted shall not affect the transfer in flight.
REQ-023 Simultaneous requests shall be served one byte per grant, in rotation. No requester shall wait more than NREQ-1 transfers.
REQ-024 A req bit that drops before grant shall be treated as withdrawn, with no ack.
REQ-025 With NREQ not a power of two, the round-robin pointer shall wrap from NREQ-1 to 0.

Reset
REQ-026 While rst is 0: state is IDLE, last is NREQ-1 (requester 0 wins first), and grant, ack, busy, new_dat, timeout, tx_dat, tx_done_q and the timeout counter are all 0.
REQ-027 Reset asserted mid-transfer shall force new_dat to 0 and grant to 0 on the next edge. No ack shall be issued for the aborted byte.
REQ-028 Resetting the uart_tx is the integrator's job and is outside this block.

Configuration
REQ-029 With macro UART_ARB_TIMEOUT_EN defined: a 16-bit counter clears on entering ISSUE and increments every ISSUE cycle.
REQ-030 With the macro, when the counter reaches TIMEOUT_CYC without a rise, the block shall pulse timeout for 1 clk and force new_dat and grant to 0. It shall issue no ack, keep last advanced, and go to RELEASE.
REQ-031 With the macro, a rise in the same cycle the counter reaches TIMEOUT_CYC shall count as success: ack, no timeout.
REQ-032 Without UART_ARB_TIMEOUT_EN: no counter shall be built, timeout shall be tied to 0, and ISSUE waits indefinitely.

Verification
REQ-033 Single requester: rst high, req=4'b0001, byte0=8'hA5. Required: grant=0001 and new_dat=1 one clk later, tx_dat=A5, ack[0] pulses exactly once at the tx_done rise, busy drops after tx_done falls.
REQ-034 Rotation: req=4'b1111 held, bytes 11/22/33/44. Required: the uart_tx line carries bytes in order 11, 22, 33, 44, 11; each ack is a single pulse.
REQ-035 Fairness after wrap: last=2, req=4'b0101. Required: requester 0 is served before requester 2.
REQ-036 Mid-transfer reset: rst=0 for 1 clk during ISSUE with grant=0010. Required: next edge shows new_dat=0, grant=0, ack=0; after release, requester 0 wins first.
REQ-037 Timeout with the macro defined, TIMEOUT_CYC=100, tx_done held 0. Required: timeout pulses at cycle 100 of ISSUE, no ack, and the next requester in rotation is granted after IDLE.
REQ-038 Stale done: tx_done held high while req=0001. Required: no grant until tx_done falls, then grant one clk later.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one uart_tx, one byte per grant.
// Optional issue watchdog is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_dat,
  output logic [NREQ-1:0]     ack,
  output logic [NREQ-1:0]     grant,
  output logic                busy,
  output logic                new_dat,
  output logic [7:0]          tx_dat,
  input  logic                tx_done,
  output logic                timeout
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT_CYC 1..65535");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

  state_t          state_q;
  logic [IW-1:0]   last_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] ack_q;
  logic            busy_q;
  logic            new_dat_q;
  logic [7:0]      tx_dat_q;
  logic            tx_done_q;

  logic            found;
  logic [IW-1:0]   win;
  logic [IW-1:0]   cand;
  logic [7:0]      win_byte;
  logic            rise;
  logic            to_hit;

  // Search starts one past the last owner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    win_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) win_byte = req_dat[8*i +: 8];
    end
    rise = tx_done & ~tx_done_q;
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

  logic [15:0] cnt_q;
  logic        timeout_q;

  // A rise landing on the limit cycle wins over the watchdog.
  assign to_hit  = (state_q == ISSUE) && ((cnt_q + 16'd1) == TO_LIM) && !rise;
  assign timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_hit;
      if (state_q == IDLE)       cnt_q <= '0;
      else if (state_q == ISSUE) cnt_q <= cnt_q + 16'd1;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_q    <= IW'(NREQ - 1);
      grant_q   <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      new_dat_q <= 1'b0;
      tx_dat_q  <= '0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= tx_done;
      ack_q     <= '0;
      case (state_q)
        IDLE: begin
          // A stale tx_done from a previous byte blocks any new issue.
          if (found && !tx_done) begin
            state_q   <= ISSUE;
            grant_q   <= NREQ'(1) << win;
            tx_dat_q  <= win_byte;
            new_dat_q <= 1'b1;
            last_q    <= win;
            busy_q    <= 1'b1;
          end
        end
        ISSUE: begin
          if (rise) begin
            new_dat_q <= 1'b0;
            ack_q     <= grant_q;
            state_q   <= RELEASE;
          end else if (to_hit) begin
            new_dat_q <= 1'b0;
            grant_q   <= '0;
            state_q   <= RELEASE;
          end
        end
        RELEASE: begin
          if (!tx_done) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          grant_q   <= '0;
          busy_q    <= 1'b0;
          new_dat_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant   = grant_q;
  assign ack     = ack_q;
  assign busy    = busy_q;
  assign new_dat = new_dat_q;
  assign tx_dat  = tx_dat_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a
// transaction-level round-robin model of who should own the uart next.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_dat;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              new_dat;
  logic [7:0]        tx_dat;
  logic              tx_done;
  logic              timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dat(req_dat), .ack(ack),
    .grant(grant), .busy(busy), .new_dat(new_dat), .tx_dat(tx_dat),
    .tx_done(tx_done), .timeout(timeout)
  );

  int         n_chk  = 0;
  int         n_pass = 0;
  bit         pend  [NREQ];
  logic [7:0] bytev [NREQ];
  int         last_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = pend[i];
      req_dat[8*i +: 8] = pend[i] ? bytev[i] : 8'($urandom);
    end
  endtask

  // Next owner: first pending requester after the last one served, wrapping.
  function automatic int exp_winner();
    for (int k = 1; k <= NREQ; k++) begin
      if (pend[(last_m + k) % NREQ]) return (last_m + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    tx_done = 1'b0;
    apply();
    step();
    rst = 1'b1;
    last_m = NREQ - 1;
  endtask

  // One complete byte: grant, hold for dly cycles, tx_done high for dlen cycles, release.
  task automatic do_xfer(input int dly, input int dlen, input bit rearm, input bit mutate,
                         output int w, output logic [7:0] b);
    logic [NREQ-1:0] oh;
    bit bad;
    w = exp_winner();
    if (w < 0) begin
      pend[0]  = 1'b1;
      bytev[0] = 8'($urandom);
      w = exp_winner();
    end
    b  = bytev[w];
    oh = NREQ'(1) << w;
    apply();
    step();
    chk("grant", 32'(grant), 32'(oh));
    chk("new_dat", 32'(new_dat), 32'd1);
    chk("tx_dat", 32'(tx_dat), 32'(b));
    chk("busy_on", 32'(busy), 32'd1);
    if (mutate) begin
      for (int i = 0; i < NREQ; i++) begin
        if (i != w) begin
          if (pend[i] && $urandom_range(0, 3) == 0) pend[i] = 1'b0;
          else if (!pend[i] && $urandom_range(0, 1) == 1) begin
            pend[i]  = 1'b1;
            bytev[i] = 8'($urandom);
          end
        end
      end
      apply();
    end
    bad = 1'b0;
    repeat (dly) begin
      step();
      if (new_dat !== 1'b1 || tx_dat !== b || ack !== '0 || grant !== oh || timeout !== 1'b0)
        bad = 1'b1;
    end
    chk("issue_hold", 32'(bad), 32'd0);
    tx_done = 1'b1;
    step();
    chk("ack", 32'(ack), 32'(oh));
    chk("new_dat_off", 32'(new_dat), 32'd0);
    chk("grant_rel", 32'(grant), 32'(oh));
    last_m = w;
    if (!rearm) pend[w] = 1'b0;
    apply();
    bad = 1'b0;
    repeat (dlen - 1) begin
      step();
      if (ack !== '0 || grant !== oh || busy !== 1'b1) bad = 1'b1;
    end
    chk("release_hold", 32'(bad), 32'd0);
    tx_done = 1'b0;
    step();
    chk("grant_clr", 32'(grant), 32'd0);
    chk("busy_off", 32'(busy), 32'd0);
    chk("ack_off", 32'(ack), 32'd0);
  endtask

  initial begin
    int         w;
    logic [7:0] b;
    logic [7:0] rot_exp [5];
    rot_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    rst = 1'b0; req = '0; req_dat = '0; tx_done = 1'b0;
    for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b0; bytev[i] = '0; end
    last_m = NREQ - 1;
    step(); step();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_new_dat", 32'(new_dat), 32'd0);
    chk("rst_tx_dat", 32'(tx_dat), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b1;

    // Single requester
    pend[0] = 1'b1; bytev[0] = 8'hA5;
    do_xfer(3, 2, 1'b0, 1'b0, w, b);
    chk("single_idx", 32'(w), 32'd0);

    // Rotation with all four held
    do_reset();
    for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b1; bytev[i] = 8'(8'h11 * (i + 1)); end
    for (int n = 0; n < 5; n++) begin
      do_xfer(2, 2, 1'b1, 1'b0, w, b);
      chk("rot_byte", 32'(b), 32'(rot_exp[n]));
    end

    // Fairness after wrap: last=2, then 0 and 2 both requesting
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    pend[2] = 1'b1; bytev[2] = 8'h5C;
    do_xfer(1, 1, 1'b0, 1'b0, w, b);
    pend[0] = 1'b1; bytev[0] = 8'h0F; pend[2] = 1'b1;
    do_xfer(1, 1, 1'b0, 1'b0, w, b);
    chk("fair_first", 32'(w), 32'd0);
    do_xfer(1, 1, 1'b0, 1'b0, w, b);
    chk("fair_second", 32'(w), 32'd2);

    // Stale tx_done blocks the grant
    pend[1] = 1'b1; bytev[1] = 8'h77;
    tx_done = 1'b1;
    apply();
    begin
      bit bad = 1'b0;
      repeat (4) begin
        step();
        if (grant !== '0 || new_dat !== 1'b0) bad = 1'b1;
      end
      chk("stale_done_block", 32'(bad), 32'd0);
    end
    tx_done = 1'b0;
    step();
    step();
    do_xfer(1, 1, 1'b0, 1'b0, w, b);
    chk("stale_done_idx", 32'(w), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      do_xfer($urandom_range(0, 15), $urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'b1, w, b);
    end

    // Reset in the middle of an issue
    do_reset();
    pend[1] = 1'b1; bytev[1] = 8'h5A;
    apply();
    step();
    chk("mr_grant", 32'(grant), 32'h2);
    step();
    rst = 1'b0;
    step();
    chk("mr_new_dat", 32'(new_dat), 32'd0);
    chk("mr_grant_clr", 32'(grant), 32'd0);
    chk("mr_ack", 32'(ack), 32'd0);
    rst = 1'b1;
    last_m = NREQ - 1;
    pend[0] = 1'b1; bytev[0] = 8'h3C;
    do_xfer(2, 1, 1'b0, 1'b0, w, b);
    chk("mr_first", 32'(w), 32'd0);

`ifdef UART_ARB_TIMEOUT_EN
    do_reset();
    pend[0] = 1'b1; bytev[0] = 8'hE1;
    pend[1] = 1'b1; bytev[1] = 8'hE2;
    apply();
    step();
    chk("to_grant", 32'(grant), 32'h1);
    begin
      bit bad = 1'b0;
      repeat (TO - 1) begin
        step();
        if (timeout !== 1'b0 || new_dat !== 1'b1) bad = 1'b1;
      end
      chk("to_early", 32'(bad), 32'd0);
    end
    step();
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_new_dat", 32'(new_dat), 32'd0);
    chk("to_grant_clr", 32'(grant), 32'd0);
    chk("to_ack", 32'(ack), 32'd0);
    step();
    chk("to_pulse_end", 32'(timeout), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);
    last_m = 0;
    do_xfer(1, 1, 1'b0, 1'b0, w, b);
    chk("to_next", 32'(w), 32'd1);
`else
    do_reset();
    pend[2] = 1'b1; bytev[2] = 8'hC3;
    do_xfer(TO + 50, 1, 1'b0, 1'b0, w, b);
    chk("no_to_idx", 32'(w), 32'd2);
    chk("no_to_out", 32'(timeout), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
